// File: rtl/spi_frame_ctrl.sv
// Frame controller behind the SPI byte receiver: one opcode per chip-select
// frame, driving pixel-RAM writes, the config byte and LED refresh requests.
module spi_frame_ctrl #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_cs_n_i,
    input  logic                  byte_vld_i,
    input  logic [7:0]            byte_data_i,
    input  logic                  busy_i,
    output logic                  ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [7:0]            ram_wr_data_o,
    output logic [7:0]            cfg_o,
    output logic                  refresh_o,
    output logic [7:0]            err_cnt_o
);

    localparam logic [7:0] OP_CONF    = 8'h2A;
    localparam logic [7:0] OP_ADDR    = 8'h2B;
    localparam logic [7:0] OP_DATA    = 8'h2C;
    localparam logic [7:0] OP_REFRESH = 8'h2D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONF,
        S_ADDR_H,
        S_ADDR_L,
        S_DATA,
        S_IGNORE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [7:0]            addr_hi;
    logic                  ref_pend;
    logic                  fire;
    logic [15:0]           addr_full;

    // The pulse depends on busy_i in the same cycle, so it is decoded from
    // the pending flag rather than registered; pending clears as it fires.
    assign fire      = ref_pend & ~busy_i;
    assign refresh_o = fire;
    assign addr_full = {addr_hi, byte_data_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            ptr           <= '0;
            addr_hi       <= '0;
            ref_pend      <= 1'b0;
            ram_wr_en_o   <= 1'b0;
            ram_wr_addr_o <= '0;
            ram_wr_data_o <= '0;
            cfg_o         <= '0;
            err_cnt_o     <= '0;
        end else begin
            ram_wr_en_o <= 1'b0;
            if (fire)
                ref_pend <= 1'b0;

            if (spi_cs_n_i) begin
                state <= S_IDLE;
            end else if (byte_vld_i) begin
                case (state)
                    S_IDLE: begin
                        case (byte_data_i)
                            OP_CONF: state <= S_CONF;
                            OP_ADDR: state <= S_ADDR_H;
                            OP_DATA: state <= S_DATA;
                            OP_REFRESH: begin
                                state <= S_IGNORE;
                                // a request while one is pending (even one firing now) merges into it
                                if (!ref_pend)
                                    ref_pend <= 1'b1;
                            end
                            default: begin
                                state <= S_IGNORE;
                                if (err_cnt_o != 8'hFF)
                                    err_cnt_o <= err_cnt_o + 8'd1;
                            end
                        endcase
                    end
                    S_CONF: begin
                        cfg_o <= byte_data_i;
                        state <= S_IGNORE;
                    end
                    S_ADDR_H: begin
                        addr_hi <= byte_data_i;
                        state   <= S_ADDR_L;
                    end
                    S_ADDR_L: begin
                        ptr   <= addr_full[ADDR_WIDTH-1:0];
                        state <= S_IGNORE;
                    end
                    S_DATA: begin
                        ram_wr_en_o   <= 1'b1;
                        ram_wr_addr_o <= ptr;
                        ram_wr_data_o <= byte_data_i;
                        ptr           <= ptr + ADDR_WIDTH'(1);
                    end
                    default: state <= S_IGNORE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed bench for spi_frame_ctrl: a table of whole frames with expected
// results, then hand sequences for latency, refresh, CS and reset corners.
module tb_spi_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_i, spi_cs_n_i, byte_vld_i, busy_i;
    logic [7:0] byte_data_i;
    logic       ram_wr_en_o, refresh_o;
    logic [9:0] ram_wr_addr_o;
    logic [7:0] ram_wr_data_o, cfg_o, err_cnt_o;

    spi_frame_ctrl #(.ADDR_WIDTH(10)) dut (
        .clk_i(clk), .rst_i(rst_i), .spi_cs_n_i(spi_cs_n_i),
        .byte_vld_i(byte_vld_i), .byte_data_i(byte_data_i), .busy_i(busy_i),
        .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o),
        .ram_wr_data_o(ram_wr_data_o), .cfg_o(cfg_o), .refresh_o(refresh_o),
        .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;
    int mon_wr = 0, mon_ref = 0;
    int mon_fa, mon_fd, mon_la, mon_ld;
    logic       last_we, last_ref;
    logic [9:0] last_addr;
    logic [7:0] last_data;

    // Observe each completed cycle just before the edge ends it.
    always @(posedge clk) begin
        if (ram_wr_en_o === 1'b1) begin
            if (mon_wr == 0) begin
                mon_fa = int'(ram_wr_addr_o);
                mon_fd = int'(ram_wr_data_o);
            end
            mon_la = int'(ram_wr_addr_o);
            mon_ld = int'(ram_wr_data_o);
            mon_wr++;
        end
        if (refresh_o === 1'b1)
            mon_ref++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic mon_clear();
        mon_wr = 0; mon_ref = 0; mon_fa = -1; mon_fd = -1; mon_la = -1; mon_ld = -1;
    endtask

    // Byte valid for one cycle; outputs captured in the following cycle.
    task automatic send_byte(input logic [7:0] b);
        byte_vld_i  = 1'b1;
        byte_data_i = b;
        @(negedge clk);
        byte_vld_i = 1'b0;
        last_we   = ram_wr_en_o;
        last_ref  = refresh_o;
        last_addr = ram_wr_addr_o;
        last_data = ram_wr_data_o;
    endtask

    task automatic run_frame(input int n, input logic [7:0] b0, input logic [7:0] b1 = 8'h00,
                             input logic [7:0] b2 = 8'h00, input logic [7:0] b3 = 8'h00);
        logic [7:0] bb [4];
        bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
        @(negedge clk);
        spi_cs_n_i = 1'b0;
        for (int i = 0; i < n; i++) send_byte(bb[i]);
        spi_cs_n_i = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        int         n;
        logic [7:0] b [4];
        int         wr, fa, fd, la, ld, rf, cfg, err;
    } vec_t;
    vec_t vec [9];

    task automatic set_vec(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int wr,
                           input int fa, input int fd, input int la, input int ld,
                           input int rf, input int cfg, input int err);
        vec[i].n = n;
        vec[i].b[0] = b0; vec[i].b[1] = b1; vec[i].b[2] = b2; vec[i].b[3] = b3;
        vec[i].wr = wr; vec[i].fa = fa; vec[i].fd = fd; vec[i].la = la; vec[i].ld = ld;
        vec[i].rf = rf; vec[i].cfg = cfg; vec[i].err = err;
    endtask

    initial begin
        set_vec(0, 3, 8'h2B, 8'h01, 8'h23, 8'h00, 0,     0,    0,     0,    0, 0, 8'h00, 0);
        set_vec(1, 4, 8'h2C, 8'hAA, 8'hBB, 8'hCC, 3, 'h123, 'hAA, 'h125, 'hCC, 0, 8'h00, 0);
        set_vec(2, 3, 8'h2B, 8'h07, 8'hFF, 8'h00, 0,     0,    0,     0,    0, 0, 8'h00, 0);
        set_vec(3, 3, 8'h2C, 8'h11, 8'h22, 8'h00, 2, 'h3FF, 'h11, 'h000, 'h22, 0, 8'h00, 0);
        set_vec(4, 2, 8'h2A, 8'h5C, 8'h00, 8'h00, 0,     0,    0,     0,    0, 0, 8'h5C, 0);
        set_vec(5, 4, 8'h55, 8'h01, 8'h02, 8'h03, 0,     0,    0,     0,    0, 0, 8'h5C, 1);
        set_vec(6, 1, 8'h2D, 8'h00, 8'h00, 8'h00, 0,     0,    0,     0,    0, 1, 8'h5C, 1);
        set_vec(7, 3, 8'h2A, 8'h3C, 8'h77, 8'h00, 0,     0,    0,     0,    0, 0, 8'h3C, 1);
        set_vec(8, 2, 8'h2C, 8'h33, 8'h00, 8'h00, 1, 'h001, 'h33, 'h001, 'h33, 0, 8'h3C, 1);

        rst_i = 1'b1; spi_cs_n_i = 1'b1; byte_vld_i = 1'b0; byte_data_i = 8'h00; busy_i = 1'b0;
        mon_clear();
        repeat (3) @(negedge clk);
        chk("rst_we",  int'(ram_wr_en_o), 0);
        chk("rst_ref", int'(refresh_o), 0);
        chk("rst_cfg", int'(cfg_o), 0);
        chk("rst_err", int'(err_cnt_o), 0);
        chk("rst_addr", int'(ram_wr_addr_o), 0);
        rst_i = 1'b0;

        for (int i = 0; i < 9; i++) begin
            mon_clear();
            run_frame(vec[i].n, vec[i].b[0], vec[i].b[1], vec[i].b[2], vec[i].b[3]);
            chk($sformatf("v%0d_wr", i),  mon_wr, vec[i].wr);
            chk($sformatf("v%0d_ref", i), mon_ref, vec[i].rf);
            chk($sformatf("v%0d_cfg", i), int'(cfg_o), vec[i].cfg);
            chk($sformatf("v%0d_err", i), int'(err_cnt_o), vec[i].err);
            if (vec[i].wr > 0) begin
                chk($sformatf("v%0d_faddr", i), mon_fa, vec[i].fa);
                chk($sformatf("v%0d_fdata", i), mon_fd, vec[i].fd);
                chk($sformatf("v%0d_laddr", i), mon_la, vec[i].la);
                chk($sformatf("v%0d_ldata", i), mon_ld, vec[i].ld);
            end
        end

        // Write latency is exactly one cycle and the strobe is a single pulse.
        run_frame(3, 8'h2B, 8'h01, 8'h00);
        @(negedge clk);
        spi_cs_n_i = 1'b0;
        send_byte(8'h2C);
        chk("lat_no_we_op", int'(last_we), 0);
        send_byte(8'hDD);
        chk("lat_we",   int'(last_we), 1);
        chk("lat_addr", int'(last_addr), 'h100);
        chk("lat_data", int'(last_data), 'hDD);
        @(negedge clk);
        chk("lat_we_drop", int'(ram_wr_en_o), 0);
        spi_cs_n_i = 1'b1;
        repeat (2) @(negedge clk);

        // Immediate refresh with the engine idle.
        spi_cs_n_i = 1'b0;
        send_byte(8'h2D);
        chk("ref_now", int'(last_ref), 1);
        @(negedge clk);
        chk("ref_one_cycle", int'(refresh_o), 0);
        spi_cs_n_i = 1'b1;
        repeat (2) @(negedge clk);

        // Two requests while busy collapse into one pulse on busy falling.
        mon_clear();
        busy_i = 1'b1;
        run_frame(1, 8'h2D);
        run_frame(1, 8'h2D);
        repeat (12) @(negedge clk);
        chk("busy_hold", mon_ref, 0);
        busy_i = 1'b0;
        #1;
        chk("busy_fall_ref", int'(refresh_o), 1);
        repeat (6) @(negedge clk);
        chk("busy_single", mon_ref, 1);

        // Truncated ADDR_WR leaves the pointer alone.
        run_frame(2, 8'h2B, 8'h02);
        mon_clear();
        run_frame(2, 8'h2C, 8'h44);
        chk("cut_addr_wr",   mon_wr, 1);
        chk("cut_addr_addr", mon_fa, 'h101);
        chk("cut_addr_data", mon_fd, 'h44);

        // A byte strobed in the same cycle CS rises is dropped.
        @(negedge clk);
        spi_cs_n_i = 1'b0;
        send_byte(8'h2A);
        spi_cs_n_i  = 1'b1;
        byte_vld_i  = 1'b1;
        byte_data_i = 8'h55;
        @(negedge clk);
        byte_vld_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("cs_vld_err", int'(err_cnt_o), 1);
        chk("cs_vld_cfg", int'(cfg_o), 'h3C);
        run_frame(2, 8'h2A, 8'h5C);
        chk("cs_conf", int'(cfg_o), 'h5C);

        // Unknown-opcode counter saturates.
        mon_clear();
        for (int i = 0; i < 300; i++) run_frame(4, 8'h55, 8'h2C, 8'h01, 8'h02);
        chk("sat_err", int'(err_cnt_o), 'hFF);
        chk("sat_cfg", int'(cfg_o), 'h5C);
        chk("sat_no_wr", mon_wr, 0);

        // Reset in the middle of a DATA_WR frame.
        @(negedge clk);
        spi_cs_n_i = 1'b0;
        send_byte(8'h2C);
        send_byte(8'h66);
        chk("mid_we",   int'(last_we), 1);
        chk("mid_addr", int'(last_addr), 'h102);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("mrst_we",  int'(ram_wr_en_o), 0);
        chk("mrst_cfg", int'(cfg_o), 0);
        chk("mrst_err", int'(err_cnt_o), 0);
        chk("mrst_addr", int'(ram_wr_addr_o), 0);
        send_byte(8'h2D);
        chk("mrst_refresh", int'(last_ref), 1);
        send_byte(8'h77);
        chk("mrst_no_wr", int'(last_we), 0);
        spi_cs_n_i = 1'b1;
        repeat (2) @(negedge clk);
        mon_clear();
        run_frame(2, 8'h2C, 8'h88);
        chk("mrst_ptr_addr", mon_fa, 0);
        chk("mrst_ptr_data", mon_fd, 'h88);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
